// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the serial pattern generator.
//   state_t    : generator FSM states (IDLE / SHIFT / DONE)
//   clamp_len(): limits a requested frame length to the pattern width
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Frame length actually sent: never more bits than the pattern holds.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned pat_w);
    return (len > pat_w) ? pat_w : len;
  endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Request/serial-output bundle of the pattern generator.
//   start, pattern, len : frame request (driven by master)
//   x, valid, busy, done: serial stream and status (driven by slave = generator)
interface seq_pattern_gen_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic             x;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (output start, pattern, len, input  x, valid, busy, done);
  modport slave  (input  start, pattern, len, output x, valid, busy, done);
endinterface

// File: rtl/seq_bit_cnt.sv
// Loadable down-counter holding the number of frame bits still to be sent,
// counting the bit currently on x.
//   clk, rstn : clock, async active-low reset (clears value)
//   load      : load load_val (has priority over dec)
//   dec       : decrement by one
//   value     : current count
//   is_one    : value == 1, i.e. the bit on x is the last of the frame
module seq_bit_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         is_one
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     value <= '0;
    else if (load) value <= load_val;
    else if (dec)  value <= value - 1'b1;
  end

  assign is_one = (value == W'(1));

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter. Captures bus.pattern on an accepted start and
// shifts bit [len_eff-1] .. bit [0] out on x, one bit per clk.
//   clk, rstn : clock, async active-low reset (aborts any frame, no done)
//   loop      : present only when SEQ_GEN_LOOP_EN is defined; when high at
//               the last bit of a frame, the frame restarts with no gap
//   bus       : seq_pattern_gen_if slave (start/pattern/len in,
//               x/valid/busy/done out); all outputs are flop outputs
// Optional feature macro: SEQ_GEN_LOOP_EN
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W    = 8,
  parameter int LEN_W    = 4,
  parameter bit IDLE_LVL = 1'b0
) (
  input  logic               clk,
  input  logic               rstn,
`ifdef SEQ_GEN_LOOP_EN
  input  logic               loop,
`endif
  seq_pattern_gen_if.slave   bus
);

  state_t           state, nxt;
  logic [LEN_W-1:0] len_eff;
  logic [PAT_W-1:0] aligned;
  logic [PAT_W-1:0] sh;
  int               sh_amt;
  logic             accept;
  logic             cnt_load, cnt_dec, cnt_is_one;
  logic [LEN_W-1:0] cnt_val, cnt_value;
  logic             valid_d, busy_d, done_d;
  logic             valid_q, busy_q, done_q;
`ifdef SEQ_GEN_LOOP_EN
  logic [PAT_W-1:0] cap;
  logic [LEN_W-1:0] len_q;
  logic             reload;
`endif

  // Left-align the frame so its first bit sits at the MSB of the shift reg;
  // the vacated low bits hold IDLE_LVL, so x falls back to the idle level by
  // itself once the last frame bit has been shifted out.
  always_comb begin
    len_eff = LEN_W'(clamp_len(int'(bus.len), PAT_W));
    sh_amt  = PAT_W - int'(len_eff);
    aligned = (bus.pattern << sh_amt) |
              (IDLE_LVL ? ~({PAT_W{1'b1}} << sh_amt) : '0);
  end

  assign accept = (state == IDLE) && bus.start;
`ifdef SEQ_GEN_LOOP_EN
  assign reload = (state == SHIFT) && cnt_is_one && loop;
`endif

  // ---- state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= nxt;
  end

  // ---- next state and counter control
  always_comb begin
    nxt      = state;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = len_eff;
    case (state)
      IDLE: if (bus.start) begin
        cnt_load = 1'b1;
        nxt      = (len_eff == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
`ifdef SEQ_GEN_LOOP_EN
        if (reload) begin
          cnt_load = 1'b1;
          cnt_val  = len_q;
        end else
`endif
        begin
          cnt_dec = (cnt_value != '0);  // lands on 0 after the last bit
          if (cnt_is_one) nxt = DONE;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // ---- output decode of the next state, registered below
  always_comb begin
    valid_d = (nxt == SHIFT);
    busy_d  = (nxt != IDLE);
    done_d  = (nxt == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // ---- shift/capture datapath
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh <= {PAT_W{IDLE_LVL}};
    end else if (accept) begin
      sh <= aligned;
`ifdef SEQ_GEN_LOOP_EN
    end else if (reload) begin
      sh <= cap;
`endif
    end else if (state == SHIFT) begin
      sh <= {sh[PAT_W-2:0], IDLE_LVL};
    end
  end

`ifdef SEQ_GEN_LOOP_EN
  // Frame copy kept for gap-free restarts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap   <= {PAT_W{IDLE_LVL}};
      len_q <= '0;
    end else if (accept) begin
      cap   <= aligned;
      len_q <= len_eff;
    end
  end
`endif

  seq_bit_cnt #(.W(LEN_W)) u_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .value    (cnt_value),
    .is_one   (cnt_is_one)
  );

  assign bus.x     = sh[PAT_W-1];
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: reset, short/zero/clamped frames,
// mid-frame start/pattern changes, back-to-back start, async abort, and
// (with SEQ_GEN_LOOP_EN) gap-free looping. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_seq_pattern_gen;
  import seq_gen_pkg::*;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic loop = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [3:0] hist = '0;

  seq_pattern_gen_if #(.PAT_W(PAT_W), .LEN_W(LEN_W)) bus ();

  seq_pattern_gen #(.PAT_W(PAT_W), .LEN_W(LEN_W), .IDLE_LVL(1'b0)) dut (
    .clk  (clk),
    .rstn (rstn),
`ifdef SEQ_GEN_LOOP_EN
    .loop (loop),
`endif
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Outputs of a cycle that carries frame bit b.
  task automatic chk_bit(input string tag, input logic b);
    check({tag, "_valid"}, bus.valid, 1'b1);
    check({tag, "_x"},     bus.x,     b);
    check({tag, "_busy"},  bus.busy,  1'b1);
    check({tag, "_done"},  bus.done,  1'b0);
    hist = {hist[2:0], bus.x};
  endtask

  task automatic chk_done(input string tag);
    check({tag, "_done"},  bus.done,  1'b1);
    check({tag, "_busy"},  bus.busy,  1'b1);
    check({tag, "_valid"}, bus.valid, 1'b0);
    check({tag, "_x"},     bus.x,     1'b0);
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_done"},  bus.done,  1'b0);
    check({tag, "_busy"},  bus.busy,  1'b0);
    check({tag, "_valid"}, bus.valid, 1'b0);
    check({tag, "_x"},     bus.x,     1'b0);
  endtask

  initial begin
    logic [7:0] a5;
    a5 = 8'hA5;
    bus.start = 1'b0; bus.pattern = '0; bus.len = '0;

    // reset
    step();
    chk_idle("reset");
    rstn = 1'b1;
    step();

    // 1: 0000_1011 len 4 -> 1,0,1,1 then done
    bus.pattern = 8'b0000_1011; bus.len = 4'd4; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    chk_bit("s1_b0", 1'b1); step();
    chk_bit("s1_b1", 1'b0); step();
    chk_bit("s1_b2", 1'b1); step();
    chk_bit("s1_b3", 1'b1);
    check("s1_detect", hist, 4'b1011);
    step();
    chk_done("s1_end"); step();
    chk_idle("s1_idle");

    // 2: len 0 -> no valid, done right after the accepting edge, busy 1 cycle
    bus.len = 4'd0; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    chk_done("s2_end"); step();
    chk_idle("s2_idle");

    // 3: len 12 clamps to 8; A5 sent MSB first
    bus.pattern = 8'hA5; bus.len = 4'd12; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      chk_bit($sformatf("s3_b%0d", 7 - i), a5[i]);
      step();
    end
    chk_done("s3_end"); step();
    chk_idle("s3_idle");

    // 4: re-pulsed start and new pattern/len mid-frame are ignored
    bus.pattern = 8'h0B; bus.len = 4'd4; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    chk_bit("s4_b0", 1'b1); step();
    bus.start = 1'b1; bus.pattern = 8'h02; bus.len = 4'd2;
    chk_bit("s4_b1", 1'b0); step();
    bus.start = 1'b0;
    chk_bit("s4_b2", 1'b1); step();
    chk_bit("s4_b3", 1'b1); step();
    chk_done("s4_end"); step();
    chk_idle("s4_idle0"); step();
    chk_idle("s4_idle1");

    // 4b: start held high -> DONE cycle + one IDLE cycle between frames
    bus.start = 1'b1;
    step();
    chk_bit("bb_f0_b0", 1'b1); step();
    chk_bit("bb_f0_b1", 1'b0); step();
    chk_done("bb_f0_end"); step();
    chk_idle("bb_gap"); step();
    bus.start = 1'b0;
    chk_bit("bb_f1_b0", 1'b1); step();
    chk_bit("bb_f1_b1", 1'b0); step();
    chk_done("bb_f1_end"); step();
    chk_idle("bb_idle");

    // 5: async reset after the 2nd bit aborts the frame without done
    bus.pattern = 8'hA5; bus.len = 4'd8; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    chk_bit("s5_b0", 1'b1); step();
    chk_bit("s5_b1", 1'b0);
    #2 rstn = 1'b0;
    #1 chk_idle("s5_async");
    step(); rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle($sformatf("s5_post%0d", i));
    end

`ifdef SEQ_GEN_LOOP_EN
    // 6: loop -> gap-free 1101 1101 1101; loop dropped in the 3rd frame
    loop = 1'b1; bus.pattern = 8'b0000_1101; bus.len = 4'd4; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      logic [3:0] p;
      p = 4'b1101;
      if (i == 8) loop = 1'b0;
      chk_bit($sformatf("s6_b%0d", i), p[3 - (i % 4)]);
      if (i % 4 == 3) check($sformatf("s6_detect%0d", i / 4), hist, 4'b1101);
      step();
    end
    chk_done("s6_end"); step();
    chk_idle("s6_idle");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #20000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
